// File: rtl/cdr_pkg.sv
// Shared types and constants for the bang-bang CDR phase controller.
// Loop states, phase-detector votes and the PI step sizes per state.
package cdr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } cdr_state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        EARLY = 2'd1,
        LATE  = 2'd2
    } vote_t;

    localparam int ACQ_STEP = 2;
    localparam int TRK_STEP = 1;

    // Alexander decode: no transition gives no information; otherwise the
    // edge sample matching the old bit means the clock is early.
    function automatic vote_t alex_vote(logic d1, logic d, logic p);
        vote_t v;
        v = NONE;
        if (d1 != d) begin
            v = (p == d1) ? EARLY : LATE;
        end
        return v;
    endfunction

endpackage

// File: rtl/cdr_phase_controller_if.sv
// Sampler-side inputs and phase-interpolator/status outputs of the CDR loop.
// master drives the sampler triplet and enable, slave is the controller.
interface cdr_phase_controller_if #(
    parameter int PI_BITS = 6
);
    logic               Enable;
    logic               Dn_1;
    logic               Dn;
    logic               Pn;
    logic [PI_BITS-1:0] Pi_code;
    logic               Pi_update;
    logic               Locked;
    logic [1:0]         State;

    modport master (
        output Enable, Dn_1, Dn, Pn,
        input  Pi_code, Pi_update, Locked, State
    );

    modport slave (
        input  Enable, Dn_1, Dn, Pn,
        output Pi_code, Pi_update, Locked, State
    );
endinterface

// File: rtl/cdr_bbpd.sv
// Bang-bang phase detector: registers the sampler triplet once and
// decodes the registered bits into an early/late/none vote.
module cdr_bbpd
    import cdr_pkg::*;
(
    input  logic  data_clock,
    input  logic  Reset,
    input  logic  Dn_1,
    input  logic  Dn,
    input  logic  Pn,
    output vote_t vote
);

    logic d1_q;
    logic d_q;
    logic p_q;

    // Capture the sampler outputs; this is the first pipeline stage.
    always_ff @(posedge data_clock) begin
        if (!Reset) begin
            d1_q <= 1'b0;
            d_q  <= 1'b0;
            p_q  <= 1'b0;
        end else begin
            d1_q <= Dn_1;
            d_q  <= Dn;
            p_q  <= Pn;
        end
    end

    // Vote decode from the registered triplet.
    always_comb begin
        vote = alex_vote(d1_q, d_q, p_q);
    end

endmodule

// File: rtl/cdr_phase_controller.sv
// Bang-bang CDR loop controller: integrates votes over fixed windows,
// steps a circular PI code and sequences acquisition/tracking/lock.
module cdr_phase_controller
    import cdr_pkg::*;
#(
    parameter int PI_BITS    = 6,
    parameter int VOTE_WIN   = 16,
    parameter int THRESH     = 4,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4
) (
    input  logic                  data_clock,
    input  logic                  Reset,
    cdr_phase_controller_if.slave bus
);

    localparam int ACC_W = $clog2(VOTE_WIN) + 2;
    localparam int WIN_W = $clog2(VOTE_WIN);
    localparam int TRN_W = $clog2(VOTE_WIN + 1);
    localparam int QC_W  = $clog2(LOCK_CNT + 1);
    localparam int SC_W  = $clog2(UNLOCK_CNT + 1);

    localparam logic signed [ACC_W-1:0] THR_P = ACC_W'(THRESH);
    localparam logic signed [ACC_W-1:0] THR_N = -THR_P;

    vote_t                     vote;
    cdr_state_t                state_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [ACC_W-1:0]   vote_val;
    logic [WIN_W-1:0]          win_q;
    logic [TRN_W-1:0]          trn_q;
    logic [TRN_W-1:0]          trn_next;
    logic [QC_W-1:0]           qc_q;
    logic [SC_W-1:0]           sc_q;
    logic [PI_BITS-1:0]        code_q;
    logic [PI_BITS-1:0]        code_next;
    logic [PI_BITS-1:0]        step_mag;
    logic                      upd_q;
    logic                      locked_q;
    logic                      win_end;
    logic                      step_up;
    logic                      step_dn;
    logic                      stepping;
    logic                      quiet;

    cdr_bbpd u_bbpd (
        .data_clock (data_clock),
        .Reset      (Reset),
        .Dn_1       (bus.Dn_1),
        .Dn         (bus.Dn),
        .Pn         (bus.Pn),
        .vote       (vote)
    );

    // Window arithmetic: this cycle's vote is folded in before deciding.
    always_comb begin
        vote_val = '0;
        unique case (vote)
            EARLY:   vote_val = ACC_W'(1);
            LATE:    vote_val = -ACC_W'(1);
            default: vote_val = '0;
        endcase
        acc_next  = acc_q + vote_val;
        trn_next  = trn_q + TRN_W'(vote != NONE);
        win_end   = (win_q == WIN_W'(VOTE_WIN - 1));
        step_up   = (acc_next >= THR_P);
        step_dn   = (acc_next <= THR_N);
        stepping  = win_end && (step_up || step_dn);
        quiet     = win_end && !stepping && (trn_next != '0);
        step_mag  = (state_q == ACQUIRE) ? PI_BITS'(ACQ_STEP)
                                         : PI_BITS'(TRK_STEP);
        code_next = step_up ? code_q + step_mag : code_q - step_mag;
    end

    // Loop FSM, integrator, lock counters and the PI code register.
    always_ff @(posedge data_clock) begin
        if (!Reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            win_q    <= '0;
            trn_q    <= '0;
            qc_q     <= '0;
            sc_q     <= '0;
            code_q   <= '0;
            upd_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            if (state_q == IDLE || !bus.Enable) begin
                acc_q    <= '0;
                win_q    <= '0;
                trn_q    <= '0;
                qc_q     <= '0;
                sc_q     <= '0;
                locked_q <= 1'b0;
                state_q  <= bus.Enable ? ACQUIRE : IDLE;
            end else begin
                if (win_end) begin
                    acc_q <= '0;
                    win_q <= '0;
                    trn_q <= '0;
                end else begin
                    acc_q <= acc_next;
                    win_q <= win_q + WIN_W'(1);
                    trn_q <= trn_next;
                end
                if (stepping) begin
                    code_q <= code_next;
                    upd_q  <= 1'b1;
                end
                unique case (state_q)
                    ACQUIRE: begin
                        if (stepping) begin
                            qc_q <= '0;
                        end else if (quiet) begin
                            if (qc_q == QC_W'(LOCK_CNT - 1)) begin
                                state_q  <= TRACK;
                                locked_q <= 1'b1;
                                qc_q     <= '0;
                                sc_q     <= '0;
                            end else begin
                                qc_q <= qc_q + QC_W'(1);
                            end
                        end
                    end
                    TRACK: begin
                        if (stepping) begin
                            if (sc_q == SC_W'(UNLOCK_CNT - 1)) begin
                                state_q  <= ACQUIRE;
                                locked_q <= 1'b0;
                                sc_q     <= '0;
                                qc_q     <= '0;
                            end else begin
                                sc_q <= sc_q + SC_W'(1);
                            end
                        end else if (quiet) begin
                            sc_q <= '0;
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.Pi_code   = code_q;
    assign bus.Pi_update = upd_q;
    assign bus.Locked    = locked_q;
    assign bus.State     = state_q;

endmodule

// File: tb/tb_cdr_phase_controller.sv
// Directed bench for the CDR phase controller.
// Expected codes and lock timing are hand-derived per window.
module tb_cdr_phase_controller;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;
    int   exp_code;
    int   pulses;

    localparam int P_NONE  = 0;
    localparam int P_EARLY = 1;
    localparam int P_LATE  = 2;

    cdr_phase_controller_if #(.PI_BITS(6)) bus ();

    cdr_phase_controller #(
        .PI_BITS    (6),
        .VOTE_WIN   (16),
        .THRESH     (4),
        .LOCK_CNT   (8),
        .UNLOCK_CNT (4)
    ) dut (
        .data_clock (clk),
        .Reset      (rst),
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int pat);
        unique case (pat)
            P_EARLY: begin bus.Dn_1 = 1'b0; bus.Dn = 1'b1; bus.Pn = 1'b0; end
            P_LATE:  begin bus.Dn_1 = 1'b1; bus.Dn = 1'b0; bus.Pn = 1'b0; end
            default: begin bus.Dn_1 = 1'b1; bus.Dn = 1'b1; bus.Pn = 1'b0; end
        endcase
    endtask

    initial begin
        n_total    = 0;
        n_bad      = 0;
        rst        = 1'b0;
        bus.Enable = 1'b0;
        drv(P_NONE);

        // reset with arbitrary inputs
        repeat (3) begin
            bus.Enable = 1'($urandom_range(0, 1));
            bus.Dn_1   = 1'($urandom_range(0, 1));
            bus.Dn     = 1'($urandom_range(0, 1));
            bus.Pn     = 1'($urandom_range(0, 1));
            tick();
        end
        chk("rst_code", int'(bus.Pi_code), 0);
        chk("rst_upd", int'(bus.Pi_update), 0);
        chk("rst_lock", int'(bus.Locked), 0);
        chk("rst_state", int'(bus.State), 0);

        // released but disabled
        bus.Enable = 1'b0;
        rst = 1'b1;
        pulses = 0;
        repeat (40) begin
            tick();
            pulses += int'(bus.Pi_update);
        end
        chk("idle_code", int'(bus.Pi_code), 0);
        chk("idle_state", int'(bus.State), 0);
        chk("idle_pulses", pulses, 0);

        // constant early: +2 per window, wraps 62 -> 0
        exp_code = 0;
        drv(P_EARLY);
        bus.Enable = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            repeat ((k == 1) ? 16 : 15) tick();
            chk("acq_quiet_cyc", int'(bus.Pi_update), 0);
            if (k == 1) chk("acq_state", int'(bus.State), 1);
            tick();
            exp_code = (exp_code + 2) % 64;
            chk("acq_upd", int'(bus.Pi_update), 1);
            chk("acq_code", int'(bus.Pi_code), exp_code);
        end
        chk("wrap_code", int'(bus.Pi_code), 0);

        // no transitions: nothing moves, no lock
        bus.Enable = 1'b0;
        tick();
        tick();
        chk("dis_state", int'(bus.State), 0);
        drv(P_NONE);
        bus.Enable = 1'b1;
        pulses = 0;
        repeat (200) begin
            tick();
            pulses += int'(bus.Pi_update);
        end
        chk("nt_pulses", pulses, 0);
        chk("nt_lock", int'(bus.Locked), 0);
        chk("nt_state", int'(bus.State), 1);
        chk("nt_code", int'(bus.Pi_code), exp_code);

        // alternating votes lock, then constant late unlocks
        bus.Enable = 1'b0;
        tick();
        tick();
        drv(P_EARLY);
        bus.Enable = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 193; i++) begin
            tick();
            if (i <= 144) pulses += int'(bus.Pi_update);
            if (i == 128) chk("alt_prelock", int'(bus.Locked), 0);
            if (i == 129) begin
                chk("alt_lock", int'(bus.Locked), 1);
                chk("alt_state", int'(bus.State), 2);
            end
            if (i == 145 || i == 161 || i == 177 || i == 193) begin
                exp_code = (exp_code + 63) % 64;
                chk("late_upd", int'(bus.Pi_update), 1);
                chk("late_code", int'(bus.Pi_code), exp_code);
            end
            if (i == 192) chk("late_still_lock", int'(bus.Locked), 1);
            if (i < 129 && (i % 2) == 0) drv(P_EARLY);
            else drv(P_LATE);
        end
        chk("alt_pulses", pulses, 0);
        chk("unlock_lock", int'(bus.Locked), 0);
        chk("unlock_state", int'(bus.State), 1);
        chk("unlock_code", int'(bus.Pi_code), 60);

        // 3 early + 13 idle per window: below threshold, still quiet
        bus.Enable = 1'b0;
        tick();
        tick();
        drv(P_EARLY);
        bus.Enable = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 129; i++) begin
            tick();
            pulses += int'(bus.Pi_update);
            if (i == 128) chk("sub_prelock", int'(bus.Locked), 0);
            if ((i % 16) < 3) drv(P_EARLY);
            else drv(P_NONE);
        end
        chk("sub_lock", int'(bus.Locked), 1);
        chk("sub_state", int'(bus.State), 2);
        chk("sub_pulses", pulses, 0);
        chk("sub_code", int'(bus.Pi_code), exp_code);

        // enable drop at window end with acc=16
        bus.Enable = 1'b0;
        tick();
        tick();
        drv(P_EARLY);
        bus.Enable = 1'b1;
        repeat (16) tick();
        chk("drop_pre_state", int'(bus.State), 1);
        bus.Enable = 1'b0;
        tick();
        chk("drop_upd", int'(bus.Pi_update), 0);
        chk("drop_state", int'(bus.State), 0);
        chk("drop_code", int'(bus.Pi_code), exp_code);
        bus.Enable = 1'b1;
        repeat (16) tick();
        chk("reen_early", int'(bus.Pi_update), 0);
        tick();
        exp_code = (exp_code + 2) % 64;
        chk("reen_upd", int'(bus.Pi_update), 1);
        chk("reen_code", int'(bus.Pi_code), exp_code);

        // reset pulse at window end with acc=16
        bus.Enable = 1'b0;
        tick();
        tick();
        bus.Enable = 1'b1;
        repeat (16) tick();
        rst = 1'b0;
        tick();
        chk("rp_upd", int'(bus.Pi_update), 0);
        chk("rp_state", int'(bus.State), 0);
        chk("rp_code", int'(bus.Pi_code), 0);
        chk("rp_lock", int'(bus.Locked), 0);
        rst = 1'b1;
        repeat (16) tick();
        chk("rp_early", int'(bus.Pi_update), 0);
        tick();
        chk("rp_step_upd", int'(bus.Pi_update), 1);
        chk("rp_step_code", int'(bus.Pi_code), 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/cdr_phase_controller.md
Name: cdr_phase_controller

Overview:
- Digital bang-bang CDR loop controller for the half-rate sampler.
- Consumes the sampler's Dn_1/Dn/Pn triplet, forms Alexander early/late votes and integrates them over fixed windows.
- Steps a circular phase-interpolator code that positions data_clock/phase_clock.
- Sequences acquisition vs. tracking and reports lock.

Parameters:
- PI_BITS, 6, phase-interpolator code width; code is circular, modulo 2^PI_BITS.
- VOTE_WIN, 16, cycles per decision window; minimum 2.
- THRESH, 4, net vote magnitude needed to step; range 1..VOTE_WIN.
- LOCK_CNT, 8, consecutive quiet windows needed to declare lock.
- UNLOCK_CNT, 4, consecutive stepping windows in TRACK that drop lock.

Ports:
- data_clock  in  1  controller clock, the recovered data clock.
- Reset  in  1  synchronous, active-low reset, sampled on posedge data_clock.
- Enable  in  1  loop enable.
- Dn_1  in  1  previous data sample.
- Dn  in  1  current data sample.
- Pn  in  1  edge (phase) sample between Dn_1 and Dn.
- Pi_code  out  PI_BITS  phase-interpolator code.
- Pi_update  out  1  one-cycle pulse, high on the cycle Pi_code takes a new value.
- Locked  out  1  high in TRACK state.
- State  out  2  current FSM state: IDLE=0, ACQUIRE=1, TRACK=2.

Behaviour:
- Single clock domain: data_clock. Reset is synchronous and active-low; all state updates on posedge data_clock.
- Reset values: Pi_code=0, Pi_update=0, Locked=0, State=IDLE. Accumulator, window counter, quiet counter, step counter and input registers all cleared.
- Stage 1: register Dn_1, Dn, Pn.
- Stage 2: vote from the registered triplet:
  - No transition (Dn_1==Dn): vote 0.
  - Transition and Pn==Dn_1: clock early, vote +1.
  - Transition and Pn==Dn: clock late, vote -1.
- Input-to-accumulator latency is 2 cycles.
- Accumulator: signed, width $clog2(VOTE_WIN)+2, so it cannot overflow. Transition counter is tracked per window.
- Window counter runs 0..VOTE_WIN-1 and only advances while State!=IDLE.
- Window end (counter==VOTE_WIN-1):
  - Evaluate acc_next, which includes this cycle's vote.
  - acc_next >= THRESH: step = +S. acc_next <= -THRESH: step = -S. Otherwise no step.
  - S = 2 in ACQUIRE, S = 1 in TRACK.
  - On a step, Pi_code <= Pi_code + step, wrapping modulo 2^PI_BITS (62+2 -> 0; 0-1 -> 63), and Pi_update=1 at that edge.
  - Accumulator, transition counter and window counter clear at the same edge.
- Quiet window: at least one transition and no step. A window with zero transitions is neutral; it does not change the quiet or step counters.
- FSM:
  - IDLE: Pi_code held, Locked=0. Enable=1 -> ACQUIRE at the next edge, window counter starts at 0.
  - ACQUIRE: a quiet window increments the quiet counter; a stepping window clears it. When the quiet counter reaches LOCK_CNT -> TRACK, Locked=1, quiet counter cleared.
  - TRACK: a stepping window increments the step counter; a quiet window clears it. When the step counter reaches UNLOCK_CNT -> ACQUIRE, Locked=0. That last step is still applied with S=1.
  - Any state with Enable=0 -> IDLE at the next edge. Accumulator and counters clear, Pi_code retained, no step applied even if the same cycle is a window end.
- Reset mid-window aborts the window; no Pi_update is generated.
- Pi_update never asserts in IDLE and never on two consecutive cycles (VOTE_WIN >= 2).

Decomposition:
- Package cdr_pkg:
  - cdr_state_t enum: IDLE, ACQUIRE, TRACK.
  - vote_t enum: NONE, EARLY, LATE.
  - Constants for step sizes: ACQ_STEP=2, TRK_STEP=1.
- Sub-module cdr_bbpd:
  - Input register stage plus Alexander vote decode, output vote_t.
  - Same clock and reset as the parent.
- Parent module holds the accumulator, window and lock/unlock counters, FSM and the Pi_code register.

Test Plan:
- Reset=0 for 3 cycles with arbitrary inputs -> Pi_code=0, Pi_update=0, Locked=0, State=0. After release with Enable=0, Pi_code stays 0 indefinitely.
- Enable=1, constant early (Dn_1=0, Dn=1, Pn=0) -> State=1. Pi_update pulses every 16 cycles, Pi_code = 2, 4, 6, ...; from code 62 the next step wraps to 0.
- Enable=1, Dn_1=Dn every cycle (no transitions) -> no votes, Pi_code holds, Locked stays 0 after 200 cycles.
- Alternating early/late votes (acc=0 each window) -> after 8 windows (about 128 cycles) Locked=1, State=2. Then constant late (Dn_1=1, Dn=0, Pn=0) -> Pi_code decrements by 1 per window, starting 0 -> 63 -> 62 -> 61 -> 60. Locked=0, State=1 at the 4th window end.
- 3 early votes per window plus 13 no-transition cycles (acc=3 < THRESH) -> no step. These count as quiet windows, so lock is reached after 8 windows.
- Drop Enable, or pulse Reset=0, at window counter=15 with acc=16 -> no Pi_update, State=0. Pi_code is retained on Enable drop and 0 on Reset. After re-enable, the first step occurs exactly 16 cycles later.
